// File: rtl/md_unit_if.sv
// Bus between the E-stage issue logic and the multiply/divide unit.
// The master drives MD instructions in; the slave returns HI/LO state and the stall request.
interface md_unit_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic        d_is_md;
   logic        busy;
   logic [31:0] read_data;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall_req;

   modport master (
      output start, op, operand1, operand2, d_is_md,
      input  busy, read_data, hi, lo, stall_req
   );

   modport slave (
      input  start, op, operand1, operand2, d_is_md,
      output busy, read_data, hi, lo, stall_req
   );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO ownership for the pipelined MIPS core.
// The result is computed at issue and held in pending registers until the fixed latency expires.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset,
   md_unit_if.slave  md
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic [31:0]        pend_hi_q, pend_hi_d;
   logic [31:0]        pend_lo_q, pend_lo_d;
   logic               pend_wr_q, pend_wr_d;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] quot_s, rem_s, quot_u, rem_u;
   logic [31:0] divisor_safe;
   logic        div_zero;
   logic        div_ovf;
   logic        arith_start;

   // Divisor is forced non-zero so the dividers never see 0; the result is discarded in that case.
   always_comb begin
      div_zero     = (md.operand2 == 32'd0);
      divisor_safe = div_zero ? 32'd1 : md.operand2;
      div_ovf      = (md.operand1 == 32'h8000_0000) && (md.operand2 == 32'hFFFF_FFFF);
      prod_s = $signed({{32{md.operand1[31]}}, md.operand1}) *
               $signed({{32{md.operand2[31]}}, md.operand2});
      prod_u = {32'd0, md.operand1} * {32'd0, md.operand2};
      quot_u = md.operand1 / divisor_safe;
      rem_u  = md.operand1 % divisor_safe;
      if (div_ovf) begin
         quot_s = 32'h8000_0000;
         rem_s  = 32'd0;
      end else begin
         quot_s = $unsigned($signed(md.operand1) / $signed(divisor_safe));
         rem_s  = $unsigned($signed(md.operand1) % $signed(divisor_safe));
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      case (state_q)
         IDLE: begin
            if (md.start) begin
               case (md.op)
                  OP_MULT: begin
                     pend_hi_d = prod_s[63:32];
                     pend_lo_d = prod_s[31:0];
                     pend_wr_d = 1'b1;
                     count_d   = CNT_W'(MULT_CYCLES);
                     state_d   = RUN;
                  end
                  OP_MULTU: begin
                     pend_hi_d = prod_u[63:32];
                     pend_lo_d = prod_u[31:0];
                     pend_wr_d = 1'b1;
                     count_d   = CNT_W'(MULT_CYCLES);
                     state_d   = RUN;
                  end
                  OP_DIV: begin
                     pend_hi_d = rem_s;
                     pend_lo_d = quot_s;
                     pend_wr_d = !div_zero;
                     count_d   = CNT_W'(DIV_CYCLES);
                     state_d   = RUN;
                  end
                  OP_DIVU: begin
                     pend_hi_d = rem_u;
                     pend_lo_d = quot_u;
                     pend_wr_d = !div_zero;
                     count_d   = CNT_W'(DIV_CYCLES);
                     state_d   = RUN;
                  end
                  OP_MTHI: hi_d = md.operand1;
                  OP_MTLO: lo_d = md.operand1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            count_d = count_q - 1'b1;
            // Final busy cycle: HI/LO become visible on the same edge that busy drops.
            if (count_q == CNT_W'(1)) begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               count_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   always_comb begin
      arith_start  = md.start && (md.op >= OP_MULT) && (md.op <= OP_DIVU);
      md.busy      = (state_q == RUN);
      md.hi        = hi_q;
      md.lo        = lo_q;
      md.stall_req = md.d_is_md && ((state_q == RUN) || arith_start);
      case (md.op)
         OP_MFHI: md.read_data = hi_q;
         OP_MFLO: md.read_data = lo_q;
         default: md.read_data = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of arithmetic vectors plus hand-written
// sequences for moves, divide by zero, stall behaviour, ignored starts and mid-operation reset.
module tb_md_unit;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          cycles;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] model_hi;
   logic [31:0] model_lo;
   vec_t vecs[7];

   always #5 clk = ~clk;

   md_unit_if mif();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mif.slave)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic start, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b, input logic d_md);
      mif.start    = start;
      mif.op       = op;
      mif.operand1 = a;
      mif.operand2 = b;
      mif.d_is_md  = d_md;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts busy cycles after the issue edge; HI/LO must hold their old value while busy.
   task automatic runBusy(input string name, input int exp_cycles);
      int n = 0;
      while (mif.busy === 1'b1 && n < 64) begin
         if (n == 0) begin
            checkOutput({name, " hi_while_busy"}, mif.hi, model_hi);
            checkOutput({name, " lo_while_busy"}, mif.lo, model_lo);
         end
         n++;
         step();
      end
      checkOutput({name, " busy_cycles"}, 32'(n), 32'(exp_cycles));
   endtask

   initial begin
      vecs[0] = '{"mult_3_m2",   4'd1, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
      vecs[1] = '{"multu_max",   4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
      vecs[2] = '{"div_m7_2",    4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[3] = '{"divu_7_2",    4'd4, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 10};
      vecs[4] = '{"div_ovf",     4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
      vecs[5] = '{"mult_maxpos", 4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
      vecs[6] = '{"div_7_m2",    4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};

      reset = 1'b0;
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      #12;
      checkOutput("reset busy", {31'd0, mif.busy}, 32'd0);
      checkOutput("reset hi", mif.hi, 32'd0);
      checkOutput("reset lo", mif.lo, 32'd0);
      checkOutput("reset stall", {31'd0, mif.stall_req}, 32'd0);
      checkOutput("reset read_data", mif.read_data, 32'd0);
      model_hi = 32'd0;
      model_lo = 32'd0;
      step();
      reset = 1'b1;
      step();

      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         step();
         applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
         runBusy(vecs[i].name, vecs[i].cycles);
         model_hi = vecs[i].exp_hi;
         model_lo = vecs[i].exp_lo;
         checkOutput({vecs[i].name, " hi"}, mif.hi, model_hi);
         checkOutput({vecs[i].name, " lo"}, mif.lo, model_lo);
         step();
      end

      // mthi followed by reads through read_data
      applyStimulus(1'b1, 4'd5, 32'h1234_5678, 32'd0, 1'b0);
      step();
      model_hi = 32'h1234_5678;
      checkOutput("mthi busy", {31'd0, mif.busy}, 32'd0);
      checkOutput("mthi hi", mif.hi, model_hi);
      checkOutput("mthi lo_unchanged", mif.lo, model_lo);
      applyStimulus(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
      #1;
      checkOutput("mfhi read_data", mif.read_data, 32'h1234_5678);
      applyStimulus(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
      #1;
      checkOutput("mflo read_data", mif.read_data, model_lo);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      #1;
      checkOutput("none read_data", mif.read_data, 32'd0);
      step();

      // Divide by zero: busy for the full divide latency, HI/LO untouched
      applyStimulus(1'b1, 4'd3, 32'd5, 32'd0, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      runBusy("div_by_zero", 10);
      checkOutput("div_by_zero hi", mif.hi, model_hi);
      checkOutput("div_by_zero lo", mif.lo, model_lo);

      // Reserved opcode in IDLE has no effect
      applyStimulus(1'b1, 4'd9, 32'hDEAD_BEEF, 32'd1, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      checkOutput("op9 busy", {31'd0, mif.busy}, 32'd0);
      checkOutput("op9 hi", mif.hi, model_hi);
      checkOutput("op9 lo", mif.lo, model_lo);

      // Stall window with d_is_md held, plus a div injected on busy cycle 3
      begin
         int n = 0;
         applyStimulus(1'b1, 4'd1, 32'd3, 32'd5, 1'b1);
         #1;
         checkOutput("stall issue_cycle", {31'd0, mif.stall_req}, 32'd1);
         step();
         applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
         while (mif.busy === 1'b1 && n < 64) begin
            checkOutput("stall busy_cycle", {31'd0, mif.stall_req}, 32'd1);
            n++;
            if (n == 3) applyStimulus(1'b1, 4'd3, 32'd100, 32'd7, 1'b1);
            else        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
            step();
         end
         checkOutput("stall busy_cycles", 32'(n), 32'd5);
         checkOutput("stall after_busy", {31'd0, mif.stall_req}, 32'd0);
         model_hi = 32'd0;
         model_lo = 32'd15;
         checkOutput("stall mult hi", mif.hi, model_hi);
         checkOutput("stall mult lo", mif.lo, model_lo);
         step();
         checkOutput("ignored div busy", {31'd0, mif.busy}, 32'd0);
      end
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

      // Reset dropped mid-divide aborts the operation at once
      applyStimulus(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      repeat (3) step();
      checkOutput("middiv still_busy", {31'd0, mif.busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("middiv reset busy", {31'd0, mif.busy}, 32'd0);
      checkOutput("middiv reset hi", mif.hi, 32'd0);
      checkOutput("middiv reset lo", mif.lo, 32'd0);
      step();
      reset = 1'b1;
      repeat (12) step();
      checkOutput("middiv no_late_commit busy", {31'd0, mif.busy}, 32'd0);
      checkOutput("middiv no_late_commit hi", mif.hi, 32'd0);
      checkOutput("middiv no_late_commit lo", mif.lo, 32'd0);
      applyStimulus(1'b1, 4'd6, 32'hA5A5_A5A5, 32'd0, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      checkOutput("mtlo lo", mif.lo, 32'hA5A5_A5A5);
      checkOutput("mtlo hi", mif.hi, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
